// File: rtl/tlk2711_rx_deframer.sv
// tlk2711_rx_deframer: TLK2711 receive deframer with link sync, length-prefixed payload
// extraction, additive checksum check and saturating good/bad frame counters.
module tlk2711_rx_deframer #(
    parameter int MAX_LEN    = 1024,
    parameter int SYNC_IDLES = 16
) (
    input  logic        rx_clk,
    input  logic        arst_n,
    input  logic [15:0] i_rxd,
    input  logic        i_rkmsb,
    input  logic        i_rklsb,
    output logic        o_link_up,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_frame_ok,
    output logic        o_frame_err,
    output logic [3:0]  o_err_code,
    output logic [15:0] o_frame_cnt,
    output logic [15:0] o_err_cnt
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(SYNC_IDLES + 1);

    typedef enum logic [2:0] {LINK_DOWN, WAIT_SOF, HDR, PAYLOAD, CSUM, EOF_CHK} state_t;

    state_t        state, state_n;
    logic [15:0]   rxd_q;
    logic [1:0]    k_q;
    logic [IW-1:0] idle_cnt, idle_n;
    logic [LW-1:0] len_cnt, len_n;
    logic [15:0]   acc, acc_n;
    logic [3:0]    err, err_n, bits;
    logic          first, first_n, fail, pass;
    logic          link_n, valid_n, sof_n, eof_n, ok_n, ferr_n;
    logic [15:0]   data_n, fcnt_n, ecnt_n;
    logic [3:0]    code_n;
    logic          is_idle, is_sof, is_eof, is_data, is_cerr, in_frame;

    function automatic logic [15:0] sat(input logic [15:0] c);
        return c + {15'd0, c != 16'hFFFF};
    endfunction

    assign is_idle  = k_q == 2'b01 && rxd_q == 16'hC5BC;
    assign is_sof   = k_q == 2'b11 && rxd_q == 16'hFBFB;
    assign is_eof   = k_q == 2'b11 && rxd_q == 16'hFDFD;
    assign is_data  = k_q == 2'b00;
    assign is_cerr  = !(is_idle || is_sof || is_eof || is_data);
    assign in_frame = state inside {HDR, PAYLOAD, CSUM, EOF_CHK};

    always_comb begin
        state_n = state;
        idle_n  = idle_cnt;
        len_n   = len_cnt;
        acc_n   = acc;
        err_n   = err;
        first_n = first;
        link_n  = o_link_up;
        valid_n = 1'b0;
        sof_n   = 1'b0;
        eof_n   = 1'b0;
        data_n  = '0;
        ok_n    = 1'b0;
        ferr_n  = 1'b0;
        code_n  = '0;
        fcnt_n  = o_frame_cnt;
        ecnt_n  = o_err_cnt;
        fail    = 1'b0;
        pass    = 1'b0;
        bits    = err;
        case (state)
            LINK_DOWN: begin
                link_n = 1'b0;
                idle_n = is_idle ? idle_cnt + 1'b1 : '0;
                if (is_idle && idle_cnt == IW'(SYNC_IDLES - 1)) begin
                    state_n = WAIT_SOF;
                    link_n  = 1'b1;
                    idle_n  = '0;
                end
            end
            WAIT_SOF: begin
                if (is_sof) begin
                    state_n = HDR;
                    err_n   = '0;
                end else if (is_cerr) begin
                    state_n = LINK_DOWN;
                    link_n  = 1'b0;
                    ecnt_n  = sat(o_err_cnt);
                end
            end
            HDR: begin
                if (is_data) begin
                    if (rxd_q == 16'd0 || int'(rxd_q) > MAX_LEN) begin
                        fail    = 1'b1;
                        bits    = 4'b0001;
                        state_n = WAIT_SOF;
                    end else begin
                        len_n   = LW'(rxd_q);
                        acc_n   = rxd_q;
                        first_n = 1'b1;
                        state_n = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (is_data) begin
                    valid_n = 1'b1;
                    data_n  = rxd_q;
                    sof_n   = first;
                    first_n = 1'b0;
                    acc_n   = acc + rxd_q;
                    len_n   = len_cnt - 1'b1;
                    if (len_cnt == LW'(1)) begin
                        eof_n   = 1'b1;
                        state_n = CSUM;
                    end
                end
            end
            CSUM: begin
                if (is_data) begin
                    err_n[2] = err[2] | (rxd_q != acc);
                    state_n  = EOF_CHK;
                end
            end
            EOF_CHK: begin
                if (is_eof) begin
                    pass    = err == 4'd0;
                    fail    = err != 4'd0;
                    state_n = WAIT_SOF;
                end else if (is_data) begin
                    fail    = 1'b1;
                    bits    = err | 4'b1000;
                    state_n = WAIT_SOF;
                end
            end
            default: state_n = LINK_DOWN;
        endcase
        // K-codes inside a frame abort it; a SOF immediately opens the next frame
        if (in_frame && !is_data && !(state == EOF_CHK && is_eof)) begin
            fail    = 1'b1;
            bits    = err | 4'b0010 | (state == EOF_CHK ? 4'b1000 : 4'b0000);
            err_n   = '0;
            link_n  = !is_cerr;
            state_n = is_sof ? HDR : is_cerr ? LINK_DOWN : WAIT_SOF;
        end
        if (fail) begin
            ferr_n = 1'b1;
            code_n = bits;
            ecnt_n = sat(o_err_cnt);
        end
        if (pass) begin
            ok_n   = 1'b1;
            fcnt_n = sat(o_frame_cnt);
        end
    end

    always_ff @(posedge rx_clk or negedge arst_n) begin
        if (!arst_n) begin
            rxd_q       <= '0;
            k_q         <= '0;
            state       <= LINK_DOWN;
            idle_cnt    <= '0;
            len_cnt     <= '0;
            acc         <= '0;
            err         <= '0;
            first       <= 1'b0;
            o_link_up   <= 1'b0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
            o_err_code  <= '0;
            o_frame_cnt <= '0;
            o_err_cnt   <= '0;
        end else begin
            rxd_q       <= i_rxd;
            k_q         <= {i_rkmsb, i_rklsb};
            state       <= state_n;
            idle_cnt    <= idle_n;
            len_cnt     <= len_n;
            acc         <= acc_n;
            err         <= err_n;
            first       <= first_n;
            o_link_up   <= link_n;
            o_data      <= data_n;
            o_valid     <= valid_n;
            o_sof       <= sof_n;
            o_eof       <= eof_n;
            o_frame_ok  <= ok_n;
            o_frame_err <= ferr_n;
            o_err_code  <= code_n;
            o_frame_cnt <= fcnt_n;
            o_err_cnt   <= ecnt_n;
        end
    end
endmodule

// File: tb/tb_tlk2711_rx_deframer.sv
// tb_tlk2711_rx_deframer: directed-vector bench for the TLK2711 receive deframer.
module tb_tlk2711_rx_deframer;
    logic        rx_clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [15:0] i_rxd = '0;
    logic        i_rkmsb = 1'b0, i_rklsb = 1'b0;
    logic        o_link_up, o_valid, o_sof, o_eof, o_frame_ok, o_frame_err;
    logic [15:0] o_data, o_frame_cnt, o_err_cnt;
    logic [3:0]  o_err_code;

    tlk2711_rx_deframer dut (
        .rx_clk(rx_clk), .arst_n(arst_n), .i_rxd(i_rxd), .i_rkmsb(i_rkmsb), .i_rklsb(i_rklsb),
        .o_link_up(o_link_up), .o_data(o_data), .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof),
        .o_frame_ok(o_frame_ok), .o_frame_err(o_frame_err), .o_err_code(o_err_code),
        .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    int total = 0, bad = 0;
    int oks = 0, both = 0;
    logic [17:0] beats[$];
    logic [3:0]  errs[$];

    // {sof, eof, data} of every valid beat, plus frame result pulses
    always @(negedge rx_clk) begin
        if (o_valid) beats.push_back({o_sof, o_eof, o_data});
        if (o_frame_err) errs.push_back(o_err_code);
        if (o_frame_ok) oks++;
        if (o_frame_ok && o_frame_err) both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] k, input logic [15:0] d);
        @(negedge rx_clk);
        {i_rkmsb, i_rklsb} = k;
        i_rxd = d;
    endtask

    task automatic idle(); send(2'b01, 16'hC5BC); endtask
    task automatic sof();  send(2'b11, 16'hFBFB); endtask
    task automatic eof();  send(2'b11, 16'hFDFD); endtask
    task automatic dat(input logic [15:0] d); send(2'b00, d); endtask
    task automatic flush(input int n); repeat (n) dat(16'h0); endtask

    task automatic frame(input int n, input logic [15:0] first, input logic [15:0] step, input logic [15:0] csum);
        sof();
        dat(16'(n));
        for (int i = 0; i < n; i++) dat(first + 16'(i) * step);
        dat(csum);
        eof();
    endtask

    int b, e, o;

    initial begin
        repeat (3) @(negedge rx_clk);
        chk("rst_outs", {o_link_up, o_valid, o_sof, o_eof, o_frame_ok, o_frame_err, o_err_code, o_data}, 0);
        chk("rst_cnt", {o_frame_cnt, o_err_cnt}, 0);
        arst_n = 1'b1;

        repeat (15) idle();
        dat(16'h0);
        repeat (15) idle();
        flush(3);
        chk("link_15_idles", o_link_up, 0);
        repeat (16) idle();
        dat(16'h0);
        chk("link_early", o_link_up, 0);
        dat(16'h0);
        chk("link_up", o_link_up, 1);

        b = beats.size();
        frame(4, 16'd1, 16'd1, 16'h000E);
        flush(3);
        chk("good_beats", beats.size() - b, 4);
        chk("good_b0", beats[b], {2'b10, 16'd1});
        chk("good_b1", beats[b+1], {2'b00, 16'd2});
        chk("good_b3", beats[b+3], {2'b01, 16'd4});
        chk("good_ok", oks, 1);
        chk("good_noerr", errs.size(), 0);
        chk("good_fcnt", o_frame_cnt, 1);

        b = beats.size();
        frame(4, 16'd1, 16'd1, 16'h000F);
        flush(3);
        chk("csum_beats", beats.size() - b, 4);
        chk("csum_nerr", errs.size(), 1);
        chk("csum_code", errs[0], 4'b0100);
        chk("csum_ecnt", o_err_cnt, 1);
        chk("csum_nok", oks, 1);

        b = beats.size();
        sof(); dat(16'd0); flush(3);
        sof(); dat(16'd1025); flush(3);
        chk("len_nerr", errs.size(), 3);
        chk("len0_code", errs[1], 4'b0001);
        chk("len_big_code", errs[2], 4'b0001);
        chk("len_nobeats", beats.size() - b, 0);
        chk("len_ecnt", o_err_cnt, 3);
        frame(1024, 16'hFFFF, 16'h0, 16'h0000);
        flush(3);
        chk("max_beats", beats.size() - b, 1024);
        chk("max_first", beats[b], {2'b10, 16'hFFFF});
        chk("max_last", beats[b+1023], {2'b01, 16'hFFFF});
        chk("max_ok", oks, 2);
        chk("max_fcnt", o_frame_cnt, 2);

        b = beats.size();
        sof(); dat(16'd3); dat(16'd10); dat(16'd11);
        frame(2, 16'd5, 16'd1, 16'h000D);
        flush(3);
        chk("sof_nerr", errs.size(), 4);
        chk("sof_code", errs[3], 4'b0010);
        chk("sof_beats", beats.size() - b, 4);
        chk("sof_abort_last", beats[b+1], {2'b00, 16'd11});
        chk("sof_new_first", beats[b+2], {2'b10, 16'd5});
        chk("sof_new_last", beats[b+3], {2'b01, 16'd6});
        chk("sof_ok", oks, 3);
        chk("sof_cnts", {o_frame_cnt, o_err_cnt}, {16'd3, 16'd4});

        b = beats.size();
        e = errs.size();
        sof(); dat(16'd2); dat(16'd7);
        send(2'b10, 16'h1234);
        @(negedge rx_clk);
        chk("cerr_early", o_frame_err, 0);
        @(negedge rx_clk);
        chk("cerr_pulse", {o_frame_err, o_err_code, o_link_up, o_valid}, {1'b1, 4'b0010, 1'b0, 1'b0});
        flush(3);
        chk("cerr_nerr", errs.size() - e, 1);
        chk("cerr_beats", beats.size() - b, 1);
        chk("cerr_beat0", beats[b], {2'b10, 16'd7});
        chk("cerr_link", o_link_up, 0);

        repeat (16) idle();
        flush(3);
        chk("relink", o_link_up, 1);
        e = errs.size();
        o = oks;
        sof(); dat(16'd3); dat(16'd1); dat(16'd2);
        repeat (2) @(negedge rx_clk);
        chk("pre_rst_beat", {o_valid, o_data}, {1'b1, 16'd2});
        #1 arst_n = 1'b0;
        #1;
        chk("arst_outs", {o_link_up, o_valid, o_sof, o_eof, o_frame_ok, o_frame_err, o_err_code, o_data}, 0);
        chk("arst_cnt", {o_frame_cnt, o_err_cnt}, 0);
        repeat (3) @(negedge rx_clk);
        arst_n = 1'b1;
        flush(4);
        chk("arst_no_err", errs.size() - e, 0);
        chk("arst_no_ok", oks - o, 0);
        chk("never_both", both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tlk2711_rx_deframer.md
Name: tlk2711_rx_deframer

Overview:
- Receive-side deframer for the TLK2711 16-bit parallel interface, clocked by rx_clk.
- Acquires link sync from idle words and delineates SOF/EOF K-code frames.
- Extracts the length-prefixed payload onto a valid-only stream, verifies the 16-bit additive checksum and counts good and bad frames.
- It is the counterpart of the tlk2711 transmit framer and sits between the tlk2711b_rxd/rkmsb/rklsb pins and the MPSoC-side capture logic.

Parameters:
- MAX_LEN, 1024, largest legal payload length in 16-bit words.
- SYNC_IDLES, 16, consecutive IDLE words required to declare link up.

Ports:
- rx_clk  input  1  receive word clock; all logic is in this single clock domain.
- arst_n  input  1  asynchronous active-low reset. Assertion is asynchronous; deassertion must be synchronous to rx_clk, supplied by reset_bridge.
- i_rxd  input  16  received word.
- i_rkmsb  input  1  K flag for i_rxd[15:8].
- i_rklsb  input  1  K flag for i_rxd[7:0].
- o_link_up  output  1  link synchronised.
- o_data  output  16  payload word.
- o_valid  output  1  o_data valid; no backpressure.
- o_sof  output  1  with o_valid, first payload word.
- o_eof  output  1  with o_valid, last payload word.
- o_frame_ok  output  1  one-cycle pulse: frame passed all checks.
- o_frame_err  output  1  one-cycle pulse: frame failed.
- o_err_code  output  4  error cause, valid with o_frame_err.
- o_frame_cnt  output  16  good frames, saturating.
- o_err_cnt  output  16  bad frames plus code errors, saturating.

Behaviour:
- Word classes, decoded from the registered input:
  - IDLE: k={msb,lsb}=01, rxd=16'hC5BC.
  - SOF: k=11, rxd=16'hFBFB.
  - EOF: k=11, rxd=16'hFDFD.
  - DATA: k=00.
  - Anything else is CODEERR.
- Input registered once. Payload reaches o_data 2 rx_clk cycles after the word is at the pins. o_frame_ok/o_frame_err are asserted 2 cycles after the EOF (or error) word arrives.
- Frame format: SOF, HDR (DATA word, value N = payload length), N DATA payload words, CSUM (DATA word), EOF.
- Checksum: CSUM = (HDR + sum of payload) mod 2^16, accumulated in a 16-bit wrapping adder.
- States:
  - LINK_DOWN: idle-run counter increments on IDLE and clears on any other word. At SYNC_IDLES go to WAIT_SOF and set o_link_up.
  - WAIT_SOF: SOF goes to HDR. IDLE/EOF/DATA are ignored. CODEERR causes err_cnt+1 and returns to LINK_DOWN with o_link_up=0; no o_frame_err.
  - HDR: DATA with 1<=N<=MAX_LEN loads the length down-counter and the accumulator, then goes to PAYLOAD. N=0 or N>MAX_LEN gives error bit0, then WAIT_SOF.
  - PAYLOAD: every DATA word is emitted with o_valid. o_sof is set on the first word and o_eof on the N-th. After the N-th word go to CSUM.
  - CSUM: a DATA word is compared with the accumulator; a mismatch sets bit2 latched. Go to EOF_CHK.
  - EOF_CHK: EOF ends the frame. The frame is ok if no bits are latched (frame_cnt+1, o_frame_ok), otherwise o_frame_err with latched bits (err_cnt+1). Any word other than EOF sets bit3 and the frame ends as an error.
- Mid-frame exceptions (HDR/PAYLOAD/CSUM/EOF_CHK):
  - IDLE or EOF: set bit1 and end the frame as an error, then WAIT_SOF.
  - SOF: set bit1, end the frame as an error, then restart directly in HDR with the new frame (the SOF is not dropped).
  - CODEERR: set bit1, end the frame as an error, then LINK_DOWN.
- Aborted frames:
  - Payload already emitted is not retracted.
  - o_eof is never asserted for an aborted frame; downstream treats o_frame_err as the discard indication.
- o_err_code bits:
  - [0] length error.
  - [1] unexpected K or code error.
  - [2] checksum mismatch.
  - [3] missing EOF.
- Counters saturate at 16'hFFFF with no wrap.
- o_frame_ok and o_frame_err are never asserted in the same cycle.
- Reset values: all outputs 0, state LINK_DOWN, counters 0. Reset mid-frame drops the frame silently; no error pulse is generated.

Test Plan:
- Reset, then 16 IDLE words: o_link_up goes to 1 on the cycle after the 16th IDLE is registered. With 15 IDLEs, a DATA word, then 15 IDLEs, o_link_up stays 0.
- Frame SOF, HDR=4, payload 0x0001/0x0002/0x0003/0x0004, CSUM=0x000E, EOF: four o_valid beats with o_sof on 0x0001 and o_eof on 0x0004, then a single o_frame_ok pulse and o_frame_cnt=1.
- Same frame with CSUM=0x000F: payload is still emitted, then o_frame_err with o_err_code=4'b0100 and o_err_cnt=1.
- HDR=0, then HDR=MAX_LEN+1: o_frame_err with code 4'b0001 each time, no o_valid. A following good frame with N=MAX_LEN passes, exercising the accumulator wrap with all payload words 0xFFFF.
- SOF, HDR=3, two payload words, SOF, then a good 2-word frame: first frame gives o_frame_err with code 4'b0010 and no o_eof; the second frame gives o_frame_ok.
- Mid-payload CODEERR word (k=10): o_frame_err with code 4'b0010 and o_link_up=0. In a separate run, asserting arst_n low mid-payload forces all outputs to 0 immediately and produces no error pulse.
